// File: rtl/serial_adder.sv
// Bit-serial adder: latches two WIDTH-bit operands and a carry-in on start,
// adds them LSB-first through one full-adder cell and a carry flip-flop,
// then presents sum/carry_out together with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  // Partial result: the bits already produced, newest at the top. The final
  // bit is merged in directly on the SHIFT->DONE edge, so WIDTH-1 bits suffice.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Full-adder cell operating on the current LSBs and the carry flip-flop.
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] res_next;

  assign bit_s    = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
  assign bit_c    = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);
  assign res_next = {bit_s, res_q};

  // Next-state and datapath update for all three states.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // start is deliberately not looked at here: a running addition
        // cannot be restarted or have its operands resampled.
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        res_d   = res_next[WIDTH-1:1];
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Visible result changes only here, so it holds through a new SHIFT.
          sum_d   = res_next;
          cout_d  = bit_c;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Datapath registers: operand shifters, result, carry, bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath is reset too, so sum/carry_out read zero after a
      // reset rather than whatever was left over from an aborted addition.
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
